rom_dl_router: RTL and testbench

- Parametrised ROM download router between data_io (ioctl_* byte stream) and the multi-port SDRAM controller's toggle-handshake write ports.
- Generalises the single-region, fire-and-forget write-request toggling to:
  - NREG address regions, each mapped to one of NPORT SDRAM ports, with a word base and a lane-packing mode.
  - A per-port FIFO that waits for the SDRAM ack before issuing the next write.
- Also produces the rom_loaded/busy status used for core reset release.

---
 rtl/rom_dl_router.sv | 150 +++++++++++++++
 tb/tb_rom_dl_router.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_router.sv
// rom_dl_router: routes the ROM download byte stream into per-port FIFOs that feed the SDRAM toggle-handshake write ports
module rom_dl_router #(
  parameter int NREG = 4,
  parameter int NPORT = 2,
  parameter int AW = 25,
  parameter int PAW = 23,
  parameter int DEPTH = 4,
  parameter int ROM_INDEX = 0,
  parameter int LANE_BIT = 13,
  parameter logic [NREG*AW-1:0] REG_BASE = {25'h0, 25'h0, 25'h0C000, 25'h0},
  parameter logic [NREG*AW-1:0] REG_SIZE = {25'h0, 25'h0, 25'h04000, 25'h0C000},
  parameter logic [NREG*PAW-1:0] REG_WBASE = {23'h0, 23'h0, 23'h4000, 23'h0},
  parameter logic [NREG*8-1:0] REG_PORT = {8'd0, 8'd0, 8'd1, 8'd0},
  parameter logic [NREG-1:0] REG_MODE = 4'b0010
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ioctl_downl,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic [AW-1:0]        ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  output logic [NPORT-1:0]     port_req,
  input  logic [NPORT-1:0]     port_ack,
  output logic [NPORT*PAW-1:0] port_a,
  output logic [NPORT*2-1:0]   port_ds,
  output logic [NPORT*16-1:0]  port_d,
  output logic [NPORT-1:0]     port_we,
  output logic                 busy,
  output logic                 rom_loaded,
  output logic                 overflow,
  output logic                 unmapped
);
  localparam int EW = PAW + 18;
  localparam int CW = $clog2(DEPTH);
  typedef enum logic {IDLE, WAIT} st_t;
  logic wr_q, wr_d, downl_q, downl_d, seen_q, seen_d, rom_loaded_q, rom_loaded_d;
  logic overflow_q, overflow_d, unmapped_q, unmapped_d, stg_vld_q, stg_vld_d;
  logic [7:0] stg_port_q, stg_port_d;
  logic [EW-1:0] stg_ent_q, stg_ent_d;
  logic wr_edge, hit, lane;
  logic [AW-1:0] off, lin;
  logic [NPORT-1:0] nempty, outst, drop;
  // Detect routed write edges, pick the lowest matching region and build the FIFO entry
  always_comb begin
    wr_d = ioctl_wr;
    downl_d = ioctl_downl;
    wr_edge = ioctl_wr & ~wr_q & ioctl_downl & (ioctl_index == 8'(ROM_INDEX));
    hit = 1'b0;
    lane = 1'b0;
    off = '0;
    lin = '0;
    stg_port_d = stg_port_q;
    stg_ent_d = stg_ent_q;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (REG_PORT[i*8 +: 8] < 8'(NPORT) && ioctl_addr >= REG_BASE[i*AW +: AW] &&
          ioctl_addr - REG_BASE[i*AW +: AW] < REG_SIZE[i*AW +: AW]) begin
        hit = 1'b1;
        off = ioctl_addr - REG_BASE[i*AW +: AW];
        lane = REG_MODE[i] ? off[LANE_BIT] : off[0];
        lin = REG_MODE[i] ? (((off >> (LANE_BIT + 1)) << LANE_BIT) | (off & ((AW'(1) << LANE_BIT) - AW'(1)))) : off >> 1;
        stg_port_d = REG_PORT[i*8 +: 8];
        stg_ent_d = {REG_WBASE[i*PAW +: PAW] + PAW'(lin), lane, ~lane, ioctl_dout, ioctl_dout};
      end
    end
    stg_vld_d = wr_edge & hit;
    unmapped_d = wr_edge & ~hit;
    overflow_d = (ioctl_downl & ~downl_q) ? 1'b0 : overflow_q | (|drop);
    seen_d = seen_q | ioctl_downl;
    rom_loaded_d = rom_loaded_q | (seen_q & ~ioctl_downl & ~(|nempty) & ~(|outst) & ~stg_vld_q);
  end
  // Edge detector, decode stage and sticky status registers
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      wr_q <= 1'b0;
      downl_q <= 1'b0;
      seen_q <= 1'b0;
      rom_loaded_q <= 1'b0;
      overflow_q <= 1'b0;
      unmapped_q <= 1'b0;
      stg_vld_q <= 1'b0;
      stg_port_q <= '0;
      stg_ent_q <= '0;
    end else begin
      wr_q <= wr_d;
      downl_q <= downl_d;
      seen_q <= seen_d;
      rom_loaded_q <= rom_loaded_d;
      overflow_q <= overflow_d;
      unmapped_q <= unmapped_d;
      stg_vld_q <= stg_vld_d;
      stg_port_q <= stg_port_d;
      stg_ent_q <= stg_ent_d;
    end
  end
  for (genvar g = 0; g < NPORT; g++) begin : g_port
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [CW:0] wp_q, wp_d, rp_q, rp_d;
    logic [EW-1:0] out_q, out_d;
    st_t st_q, st_d;
    logic req_q, req_d, we_q, we_d, push, pop, full, empty, drop_l;
    // FIFO bookkeeping; the head moves into the held output register when the request is issued
    always_comb begin
      empty = wp_q == rp_q;
      full = (wp_q[CW] != rp_q[CW]) && (wp_q[CW-1:0] == rp_q[CW-1:0]);
      pop = (st_q == IDLE) && !empty && (req_q == port_ack[g]);
      push = stg_vld_q && (stg_port_q == 8'(g)) && (!full || pop);
      drop_l = stg_vld_q && (stg_port_q == 8'(g)) && full && !pop;
      mem_d = mem_q;
      if (push) mem_d[wp_q[CW-1:0]] = stg_ent_q;
      wp_d = wp_q + (CW+1)'(push);
      rp_d = rp_q + (CW+1)'(pop);
      st_d = pop ? WAIT : ((st_q == WAIT) && (port_ack[g] == req_q)) ? IDLE : st_q;
      req_d = req_q ^ pop;
      we_d = st_d == WAIT;
      out_d = pop ? mem_q[rp_q[CW-1:0]] : out_q;
    end
    // FIFO storage needs no reset; pointers define validity
    always_ff @(posedge clk_sys) mem_q <= mem_d;
    // Pointer, engine state and request toggle registers
    always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
        wp_q <= '0;
        rp_q <= '0;
        st_q <= IDLE;
        req_q <= 1'b0;
        we_q <= 1'b0;
        out_q <= '0;
      end else begin
        wp_q <= wp_d;
        rp_q <= rp_d;
        st_q <= st_d;
        req_q <= req_d;
        we_q <= we_d;
        out_q <= out_d;
      end
    end
    assign nempty[g] = !empty;
    assign outst[g] = st_q == WAIT;
    assign drop[g] = drop_l;
    assign port_req[g] = req_q;
    assign port_we[g] = we_q;
    assign {port_a[g*PAW +: PAW], port_ds[g*2 +: 2], port_d[g*16 +: 16]} = out_q;
  end
  assign busy = downl_q | (|nempty) | (|outst) | stg_vld_q;
  assign rom_loaded = rom_loaded_q;
  assign overflow = overflow_q;
  assign unmapped = unmapped_q;
endmodule

// File: tb/tb_rom_dl_router.sv
// tb_rom_dl_router: scoreboard bench for the ROM download router with a delayed-ack SDRAM port model
module tb_rom_dl_router;
  localparam int AW = 25;
  localparam int PAW = 23;
  localparam int NP = 2;
  localparam int EW = PAW + 18;
  localparam int MB[4] = '{'h0, 'hC000, 'h10000, 'h30000};
  localparam int MS[4] = '{'hC000, 'h4000, 'h100, 'h100};
  localparam int MW[4] = '{'h0, 'h4000, 'h100, 'h0};
  localparam int MP[4] = '{0, 1, 1, 2};
  localparam bit MM[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic clk_sys = 1'b0;
  logic reset;
  logic ioctl_downl, ioctl_wr;
  logic [7:0] ioctl_index, ioctl_dout;
  logic [AW-1:0] ioctl_addr;
  logic [NP-1:0] port_req, port_ack, port_we;
  logic [NP*PAW-1:0] port_a;
  logic [NP*2-1:0] port_ds;
  logic [NP*16-1:0] port_d;
  logic busy, rom_loaded, overflow, unmapped;
  int checks = 0;
  int errors = 0;
  int unm_cnt = 0;
  logic [EW-1:0] sb0[$];
  logic [EW-1:0] sb1[$];
  logic [NP-1:0] hold = '0;
  bit ack_clr = 1'b0;
  bit mon_en = 1'b1;

  rom_dl_router #(
    .NREG(4), .NPORT(NP), .AW(AW), .PAW(PAW), .DEPTH(4), .ROM_INDEX(0), .LANE_BIT(13),
    .REG_BASE({25'h30000, 25'h10000, 25'h0C000, 25'h0}),
    .REG_SIZE({25'h100, 25'h100, 25'h4000, 25'hC000}),
    .REG_WBASE({23'h0, 23'h100, 23'h4000, 23'h0}),
    .REG_PORT({8'd2, 8'd1, 8'd1, 8'd0}),
    .REG_MODE(4'b0010)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port_req(port_req), .port_ack(port_ack), .port_a(port_a), .port_ds(port_ds),
    .port_d(port_d), .port_we(port_we), .busy(busy), .rom_loaded(rom_loaded),
    .overflow(overflow), .unmapped(unmapped)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic bit model(input logic [AW-1:0] addr, input logic [7:0] dat,
                               output int port, output logic [EW-1:0] ent);
    logic [AW-1:0] off;
    logic [PAW-1:0] w;
    logic ln;
    port = 0;
    ent = '0;
    for (int i = 0; i < 4; i++) begin
      if (MP[i] < NP && addr >= AW'(MB[i]) && addr < AW'(MB[i] + MS[i])) begin
        off = addr - AW'(MB[i]);
        if (MM[i]) begin
          ln = off[13];
          w = PAW'(MW[i]) + PAW'({off[AW-1:14], off[12:0]});
        end else begin
          ln = off[0];
          w = PAW'(MW[i]) + PAW'(off[AW-1:1]);
        end
        port = MP[i];
        ent = {w, ln, ~ln, dat, dat};
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt[NP];
    port_ack = '0;
    cnt = '{default: 0};
    forever begin
      @(negedge clk_sys);
      if (ack_clr) begin
        port_ack = '0;
        cnt = '{default: 0};
      end else begin
        for (int p = 0; p < NP; p++) begin
          if (port_req[p] == port_ack[p]) cnt[p] = 0;
          else if (!hold[p]) begin
            cnt[p]++;
            if (cnt[p] >= 3) begin
              port_ack[p] = port_req[p];
              cnt[p] = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [NP-1:0] prev;
    logic [EW-1:0] got, ex;
    prev = '0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (unmapped === 1'b1) unm_cnt++;
      for (int p = 0; p < NP; p++) begin
        if (mon_en && port_req[p] !== prev[p]) begin
          got = {port_a[p*PAW +: PAW], port_ds[p*2 +: 2], port_d[p*16 +: 16]};
          checks++;
          if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
            errors++;
            $display("FAIL sb_port%0d: unexpected request got %h expected none", p, got);
          end else begin
            if (p == 0) ex = sb0.pop_front();
            else ex = sb1.pop_front();
            if (got !== ex || port_we[p] !== 1'b1) begin
              errors++;
              $display("FAIL sb_port%0d: got %h we %b expected %h we 1", p, got, port_we[p], ex);
            end
          end
        end
      end
      prev = port_req;
    end
  end

  task automatic write_byte(input logic [AW-1:0] a, input logic [7:0] dat, input logic [7:0] idx, input bit exp);
    int p;
    logic [EW-1:0] e;
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_dout = dat;
    ioctl_index = idx;
    ioctl_wr = 1'b1;
    if (exp && model(a, dat, p, e)) begin
      if (p == 0) sb0.push_back(e);
      else sb1.push_back(e);
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk_sys);
      #1;
      if (sb0.size() == 0 && sb1.size() == 0 && port_we == '0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk_sys);
    #1;
    checks += 5;
    if (port_req !== '0 || port_we !== '0) begin
      errors++;
      $display("FAIL reset_req_we: got req %b we %b expected 0 0", port_req, port_we);
    end
    if ({port_a, port_ds, port_d} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {port_a, port_ds, port_d});
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    if (rom_loaded !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_sticky: got rl %b ovf %b expected 0 0", rom_loaded, overflow);
    end
    if (unmapped !== 1'b0) begin
      errors++;
      $display("FAIL reset_unmapped: got %b expected 0", unmapped);
    end
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    ioctl_downl = 1'b1;
  endtask

  task automatic test_latency;
    bit hi_bad, matched;
    hi_bad = 1'b0;
    matched = 1'b0;
    @(negedge clk_sys);
    ioctl_addr = 25'h3;
    ioctl_dout = 8'hA5;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b1;
    sb0.push_back({23'h1, 2'b10, 16'hA5A5});
    @(posedge clk_sys);
    #1;
    checks++;
    if (port_req[0] !== 1'b0) begin
      errors++;
      $display("FAIL lat_c0: got req %b expected 0", port_req[0]);
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(posedge clk_sys);
    #1;
    checks++;
    if (port_req[0] !== 1'b0) begin
      errors++;
      $display("FAIL lat_c1: got req %b expected 0", port_req[0]);
    end
    @(posedge clk_sys);
    #1;
    checks++;
    if (port_req[0] !== 1'b1) begin
      errors++;
      $display("FAIL lat_c2: got req %b expected 1", port_req[0]);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_sys);
      #1;
      if (port_ack[0] === port_req[0]) begin
        matched = 1'b1;
        break;
      end
      if (port_we[0] !== 1'b1) hi_bad = 1'b1;
    end
    checks += 2;
    if (hi_bad) begin
      errors++;
      $display("FAIL lat_we_hold: got we 0 during wait expected 1");
    end
    if (!matched || port_we[0] !== 1'b0) begin
      errors++;
      $display("FAIL lat_we_drop: got matched %b we %b expected 1 0", matched, port_we[0]);
    end
  endtask

  task automatic test_lane;
    bit ok;
    write_byte(25'hE005, 8'h3C, 8'd0, 1'b1);
    write_byte(25'hC005, 8'h5A, 8'd0, 1'b1);
    wait_idle(100, ok);
    checks += 2;
    if (!ok) begin
      errors++;
      $display("FAIL lane_drain: got pending %0d expected 0", sb1.size());
    end
    if (port_a[PAW +: PAW] !== 23'h4005 || port_ds[3:2] !== 2'b01 || port_d[31:16] !== 16'h5A5A) begin
      errors++;
      $display("FAIL lane_last: got a %h ds %b d %h expected 4005 01 5a5a", port_a[PAW +: PAW], port_ds[3:2], port_d[31:16]);
    end
  endtask

  task automatic test_unmapped;
    int base;
    logic [NP-1:0] rq;
    base = unm_cnt;
    rq = port_req;
    write_byte(25'h20000, 8'h11, 8'd0, 1'b0);
    repeat (3) @(posedge clk_sys);
    #1;
    checks++;
    if (unm_cnt - base !== 1) begin
      errors++;
      $display("FAIL unm_nohit: got %0d pulses expected 1", unm_cnt - base);
    end
    write_byte(25'h0, 8'h22, 8'd1, 1'b0);
    repeat (3) @(posedge clk_sys);
    #1;
    checks++;
    if (unm_cnt - base !== 1) begin
      errors++;
      $display("FAIL unm_index: got %0d pulses expected 1", unm_cnt - base);
    end
    write_byte(25'h30010, 8'h33, 8'd0, 1'b0);
    repeat (3) @(posedge clk_sys);
    #1;
    checks += 2;
    if (unm_cnt - base !== 2) begin
      errors++;
      $display("FAIL unm_badport: got %0d pulses expected 2", unm_cnt - base);
    end
    if (port_req !== rq || port_we !== '0) begin
      errors++;
      $display("FAIL unm_quiet: got req %b we %b expected %b 0", port_req, port_we, rq);
    end
  endtask

  task automatic test_rom_loaded;
    bit b1, b2, bad, seen;
    hold[0] = 1'b1;
    for (int i = 0; i < 4; i++) write_byte(25'h100 + 25'(i), 8'h40 + 8'(i), 8'd0, 1'b1);
    repeat (4) @(posedge clk_sys);
    @(negedge clk_sys);
    ioctl_downl = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++;
    if (busy !== 1'b1 || rom_loaded !== 1'b0) begin
      errors++;
      $display("FAIL rl_pending: got busy %b rl %b expected 1 0", busy, rom_loaded);
    end
    @(negedge clk_sys);
    hold[0] = 1'b0;
    b1 = 1'b1;
    b2 = 1'b1;
    bad = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_sys);
      #1;
      if (rom_loaded === 1'b1) begin
        seen = 1'b1;
        break;
      end
      b2 = b1;
      b1 = busy;
    end
    checks += 3;
    if (!seen) begin
      errors++;
      $display("FAIL rl_rise: got rl %b expected 1", rom_loaded);
    end
    if ({b2, b1} !== 2'b10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rl_timing: got busy history %b%b now %b expected 10 now 0", b2, b1, busy);
    end
    if (sb0.size() != 0) begin
      errors++;
      $display("FAIL rl_drain: got pending %0d expected 0", sb0.size());
    end
  endtask

  task automatic test_overflow;
    bit ok;
    @(negedge clk_sys);
    ioctl_downl = 1'b1;
    hold[0] = 1'b1;
    for (int i = 0; i < 6; i++) write_byte(25'h200 + 25'(i), 8'h60 + 8'(i), 8'd0, i < 5);
    repeat (3) @(posedge clk_sys);
    #1;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    @(negedge clk_sys);
    hold[0] = 1'b0;
    wait_idle(200, ok);
    checks += 2;
    if (!ok) begin
      errors++;
      $display("FAIL ovf_drain: got pending %0d expected 0", sb0.size());
    end
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
    @(negedge clk_sys);
    ioctl_downl = 1'b0;
    repeat (3) @(negedge clk_sys);
    ioctl_downl = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_mid_reset;
    bit ok;
    hold[0] = 1'b1;
    write_byte(25'h300, 8'h71, 8'd0, 1'b1);
    write_byte(25'h302, 8'h72, 8'd0, 1'b0);
    write_byte(25'h304, 8'h73, 8'd0, 1'b0);
    mon_en = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    @(posedge clk_sys);
    #1;
    checks += 3;
    if (port_req !== '0 || port_we !== '0) begin
      errors++;
      $display("FAIL mr_req: got req %b we %b expected 0 0", port_req, port_we);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mr_busy: got %b expected 0", busy);
    end
    if (rom_loaded !== 1'b0) begin
      errors++;
      $display("FAIL mr_rl: got %b expected 0", rom_loaded);
    end
    ack_clr = 1'b1;
    repeat (2) @(negedge clk_sys);
    ack_clr = 1'b0;
    hold = '0;
    sb0.delete();
    sb1.delete();
    reset = 1'b1;
    @(negedge clk_sys);
    mon_en = 1'b1;
    write_byte(25'h308, 8'h7E, 8'd0, 1'b1);
    wait_idle(100, ok);
    checks += 2;
    if (!ok) begin
      errors++;
      $display("FAIL mr_fresh: got pending %0d expected 0", sb0.size());
    end
    if (port_a[PAW-1:0] !== 23'h184 || port_d[15:0] !== 16'h7E7E) begin
      errors++;
      $display("FAIL mr_last: got a %h d %h expected 184 7e7e", port_a[PAW-1:0], port_d[15:0]);
    end
  endtask

  initial begin
    reset = 1'b0;
    ioctl_downl = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_index = 8'd0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    test_reset;
    test_latency;
    test_lane;
    test_unmapped;
    test_rom_loaded;
    test_overflow;
    test_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
